// File: rtl/rs_latch_nand_driver_if.sv
// rs_latch_nand_driver_if: request handshake, latch drive/readback and error status bundle
interface rs_latch_nand_driver_if;
    logic req_valid;
    logic req_val;
    logic req_ready;
    logic s_n;
    logic r_n;
    logic q_fb;
    logic qn_fb;
    logic done;
    logic err;
    logic err_sticky;
    logic clr_err;
    modport master (
        output req_valid, req_val, q_fb, qn_fb, clr_err,
        input  req_ready, s_n, r_n, done, err, err_sticky
    );
    modport slave (
        input  req_valid, req_val, q_fb, qn_fb, clr_err,
        output req_ready, s_n, r_n, done, err, err_sticky
    );
endinterface

// File: rtl/rs_latch_nand_driver.sv
// rs_latch_nand_driver: pulses an active-low NAND RS latch for one-bit writes and verifies the readback
module rs_latch_nand_driver #(
    parameter int PULSE_LEN = 2,
    parameter int SETTLE    = 1
) (
    input logic clk,
    input logic rst_n,
    rs_latch_nand_driver_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PULSE, SETL, CHECK} state_t;
    state_t state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic val, val_nx, err_nx;
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        val_nx   = val;
        case (state)
            IDLE:
                if (bus.req_valid && bus.req_ready) begin
                    state_nx = PULSE;
                    cnt_nx   = 8'(PULSE_LEN - 1);
                    val_nx   = bus.req_val;
                end
            PULSE:
                if (cnt == 8'd0) begin
                    state_nx = SETL;
                    cnt_nx   = 8'(SETTLE - 1);
                end else cnt_nx = cnt - 8'd1;
            SETL:
                if (cnt == 8'd0) state_nx = CHECK;
                else cnt_nx = cnt - 8'd1;
            default: state_nx = IDLE;
        endcase
        err_nx = (state == CHECK) && ((bus.q_fb != val) || (bus.qn_fb != !val));
    end
    // Drives are decoded from the next state so s_n/r_n are clean registers and never both low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            val            <= 1'b0;
            bus.s_n        <= 1'b1;
            bus.r_n        <= 1'b1;
            bus.req_ready  <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            bus.err_sticky <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            val            <= val_nx;
            bus.s_n        <= !(state_nx == PULSE && val_nx);
            bus.r_n        <= !(state_nx == PULSE && !val_nx);
            bus.req_ready  <= state_nx == IDLE;
            bus.done       <= state == CHECK;
            bus.err        <= err_nx;
            bus.err_sticky <= err_nx | (bus.err_sticky & ~bus.clr_err);
        end
    end
endmodule

// File: tb/tb_rs_latch_nand_driver.sv
// tb_rs_latch_nand_driver: directed checks of the NAND latch driver against a clocked latch model
module tb_rs_latch_nand_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    int viol = 0;
    logic qa = 1'b0, qb = 1'b0;
    logic force_q = 1'b0, fq = 1'b0, force_qn = 1'b0, fqn = 1'b0;
    rs_latch_nand_driver_if a ();
    rs_latch_nand_driver_if b ();
    rs_latch_nand_driver #(.PULSE_LEN(2), .SETTLE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
    rs_latch_nand_driver #(.PULSE_LEN(1), .SETTLE(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        qa <= !a.s_n ? 1'b1 : !a.r_n ? 1'b0 : qa;
        qb <= !b.s_n ? 1'b1 : !b.r_n ? 1'b0 : qb;
    end
    assign a.q_fb  = force_q ? fq : qa;
    assign a.qn_fb = force_qn ? fqn : !qa;
    assign b.q_fb  = qb;
    assign b.qn_fb = !qb;
    always @(negedge clk) if ((!a.s_n && !a.r_n) || (!b.s_n && !b.r_n)) viol++;
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // One write on dut_a (PULSE_LEN=2, SETTLE=1): pulse cycles 1-2, settle 3, check 4, done 5.
    task automatic wr(input string tag, input logic v, input logic e, input logic clr_at_chk);
        check({tag, "_rdy0"}, a.req_ready, 1);
        a.req_valid = 1'b1;
        a.req_val   = v;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            a.req_valid = 1'b0;
            a.req_val   = !v;
            check($sformatf("%s_s_n%0d", tag, k), a.s_n, (v && k <= 2) ? 0 : 1);
            check($sformatf("%s_r_n%0d", tag, k), a.r_n, (!v && k <= 2) ? 0 : 1);
            check($sformatf("%s_done%0d", tag, k), a.done, k == 5);
            check($sformatf("%s_err%0d", tag, k), a.err, k == 5 && e);
            check($sformatf("%s_rdy%0d", tag, k), a.req_ready, k >= 5);
            a.clr_err = clr_at_chk && k == 4;
        end
    endtask
    initial begin
        int busy, accepts, dones, errs;
        logic dn;
        a.req_valid = 0; a.req_val = 0; a.clr_err = 0;
        b.req_valid = 0; b.req_val = 0; b.clr_err = 0;
        @(posedge clk);
        #1;
        check("rst_s_n", a.s_n, 1);
        check("rst_r_n", a.r_n, 1);
        check("rst_rdy", a.req_ready, 0);
        check("rst_done", a.done, 0);
        check("rst_err", a.err, 0);
        check("rst_sticky", a.err_sticky, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_rdy", a.req_ready, 1);
        wr("set", 1, 0, 0);
        wr("reset", 0, 0, 0);
        wr("set2", 1, 0, 0);
        wr("same", 1, 0, 0);
        check("sticky_clean", a.err_sticky, 0);
        force_q = 1; fq = 0;
        wr("stuck", 1, 1, 0);
        check("sticky_set", a.err_sticky, 1);
        force_q = 0;
        wr("good", 1, 0, 0);
        check("sticky_hold", a.err_sticky, 1);
        a.clr_err = 1;
        @(negedge clk);
        a.clr_err = 0;
        check("sticky_clr", a.err_sticky, 0);
        force_q = 1;
        wr("stk2", 1, 1, 1);
        check("sticky_setwins", a.err_sticky, 1);
        force_q = 0;
        a.clr_err = 1;
        @(negedge clk);
        a.clr_err = 0;
        check("sticky_clr2", a.err_sticky, 0);
        force_qn = 1; fqn = 1;
        wr("qeqqn", 1, 1, 0);
        force_qn = 0;
        a.clr_err = 1;
        @(negedge clk);
        a.clr_err = 0;
        check("b2b_rdy0", a.req_ready, 1);
        a.req_valid = 1; a.req_val = 1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            check($sformatf("b2b_s_n%0d", k), a.s_n, ((k - 1) % 5) < 2 ? 0 : 1);
            check($sformatf("b2b_done%0d", k), a.done, (k % 5) == 0);
            if (k == 15) a.req_valid = 0;
        end
        repeat (2) @(negedge clk);
        a.req_valid = 1; a.req_val = 1;
        @(negedge clk);
        a.req_valid = 0;
        check("ar_pulse", a.s_n, 0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_s_n", a.s_n, 1);
        check("ar_r_n", a.r_n, 1);
        check("ar_rdy", a.req_ready, 0);
        check("ar_done", a.done, 0);
        repeat (2) @(negedge clk);
        check("ar_hold_rdy", a.req_ready, 0);
        rst_n = 1'b1;
        dn = 0;
        @(negedge clk);
        check("ar_rel_rdy", a.req_ready, 1);
        dn = a.done;
        repeat (6) begin
            @(negedge clk);
            dn = dn | a.done;
        end
        check("ar_no_done", dn, 0);
        busy = 0; accepts = 0; dones = 0; errs = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy > 0) busy--;
            dones += b.done;
            errs += b.err;
            if (i % 40 == 0) check($sformatf("rnd_rdy%0d", i), b.req_ready, busy == 0);
            if (b.req_valid && busy == 0) begin
                accepts++;
                busy = 6;
            end
            b.req_valid = 1'($urandom_range(0, 1));
            b.req_val   = 1'($urandom_range(0, 1));
        end
        b.req_valid = 0;
        repeat (10) begin
            @(negedge clk);
            dones += b.done;
            errs += b.err;
        end
        check("rnd_accepts_nonzero", accepts > 10, 1);
        check("rnd_done_count", dones, accepts);
        check("rnd_err", errs, 0);
        check("never_both_low", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
